// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: sends a DATA_W word one bit per TICK_DIV clocks, LSB first by default.
// Define PARITY_EN to append one even-parity bit after the data bits.
module serial_tx #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned TICK_DIV  = 5000000,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid,
   output logic              ready,
   output logic              out,
   output logic              frame,
   output logic              done
);

   localparam int unsigned IW = $clog2(DATA_W);
   localparam int unsigned CW = $clog2(TICK_DIV + 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t            state, state_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [IW-1:0]     bit_idx, bit_idx_next;
   logic [CW-1:0]     tick_cnt, tick_next;
   logic              out_next;
   logic              tick;
`ifdef PARITY_EN
   logic              par, par_next;
`endif

   assign tick  = (tick_cnt == TICK_MAX);
   assign ready = (state == IDLE);
   assign done  = (state == DONE);
`ifdef PARITY_EN
   assign frame = (state == SHIFT) || (state == PAR);
`else
   assign frame = (state == SHIFT);
`endif

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      tick_next    = tick_cnt;
      out_next     = out;
`ifdef PARITY_EN
      par_next     = par;
`endif
      case (state)
         IDLE: begin
            out_next = 1'b0;
            if (valid) begin
               state_next   = SHIFT;
               shreg_next   = data_in;
               bit_idx_next = '0;
               tick_next    = '0;
               out_next     = (MSB_FIRST != 0) ? data_in[DATA_W-1] : data_in[0];
`ifdef PARITY_EN
               par_next     = ^data_in;
`endif
            end
         end
         SHIFT: begin
            tick_next = tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
               if (bit_idx != LAST_BIT) begin
                  bit_idx_next = bit_idx + 1'b1;
                  // out is loaded with the bit that becomes the shift-out end after this shift
                  if (MSB_FIRST != 0) begin
                     shreg_next = {shreg[DATA_W-2:0], 1'b0};
                     out_next   = shreg[DATA_W-2];
                  end else begin
                     shreg_next = {1'b0, shreg[DATA_W-1:1]};
                     out_next   = shreg[1];
                  end
               end else begin
`ifdef PARITY_EN
                  state_next = PAR;
                  out_next   = par;
`else
                  state_next = DONE;
                  out_next   = 1'b0;
`endif
               end
            end
         end
`ifdef PARITY_EN
         PAR: begin
            tick_next = tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
               state_next = DONE;
               out_next   = 1'b0;
            end
         end
`endif
         DONE: begin
            state_next = IDLE;
            out_next   = 1'b0;
         end
         default: begin
            state_next = IDLE;
            out_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         tick_cnt <= '0;
         out      <= 1'b0;
`ifdef PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         shreg    <= shreg_next;
         bit_idx  <= bit_idx_next;
         tick_cnt <= tick_next;
         out      <= out_next;
`ifdef PARITY_EN
         par      <= par_next;
`endif
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance LSB-first with TICK_DIV=2, one MSB-first with TICK_DIV=1.
module tb_serial_tx;

`ifdef PARITY_EN
   localparam int unsigned NB = 9;
`else
   localparam int unsigned NB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, out_a, frame_a, done_a;
   logic       ready_b, out_b, frame_b, done_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   serial_tx #(.DATA_W(8), .TICK_DIV(2), .MSB_FIRST(0)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_a), .valid(valid_a),
      .ready(ready_a), .out(out_a), .frame(frame_a), .done(done_a)
   );

   serial_tx #(.DATA_W(8), .TICK_DIV(1), .MSB_FIRST(1)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_b), .valid(valid_b),
      .ready(ready_b), .out(out_b), .frame(frame_b), .done(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered 1 time unit after the accepting edge; leaves 1 unit after ready returns.
   task automatic check_frame(input string tag, input logic [7:0] w);
      logic b;
      for (int i = 0; i < int'(NB) * 2; i++) begin
         if (i / 2 < 8) b = w[3'(i / 2)];
         else           b = ^w;
         chk({tag, " out"},   {31'd0, out_a},   {31'd0, b});
         chk({tag, " frame"}, {31'd0, frame_a}, 32'd1);
         chk({tag, " done"},  {31'd0, done_a},  32'd0);
         chk({tag, " ready"}, {31'd0, ready_a}, 32'd0);
         @(posedge clk); #1;
      end
      chk({tag, " done pulse"}, {31'd0, done_a},  32'd1);
      chk({tag, " done out"},   {31'd0, out_a},   32'd0);
      chk({tag, " done frame"}, {31'd0, frame_a}, 32'd0);
      chk({tag, " done ready"}, {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      chk({tag, " idle ready"}, {31'd0, ready_a}, 32'd1);
      chk({tag, " idle done"},  {31'd0, done_a},  32'd0);
   endtask

   initial begin
      logic [7:0] wb;
      rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
      #1;
      chk("reset ready", {31'd0, ready_a}, 32'd1);
      chk("reset out",   {31'd0, out_a},   32'd0);
      chk("reset frame", {31'd0, frame_a}, 32'd0);
      chk("reset done",  {31'd0, done_a},  32'd0);
      chk("reset ready b", {31'd0, ready_b}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Abort in the middle of bit 3 of 8'h3C
      data_a = 8'h3C; valid_a = 1'b1;
      @(posedge clk); #1 valid_a = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort bit3 out",   {31'd0, out_a},   32'd1);
      chk("abort bit3 frame", {31'd0, frame_a}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort out",   {31'd0, out_a},   32'd0);
      chk("abort frame", {31'd0, frame_a}, 32'd0);
      chk("abort ready", {31'd0, ready_a}, 32'd1);
      chk("abort done",  {31'd0, done_a},  32'd0);
      @(posedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("post-abort done",  {31'd0, done_a},  32'd0);
         chk("post-abort ready", {31'd0, ready_a}, 32'd1);
         @(posedge clk); #1;
      end

      // Single frame 8'hA5
      data_a = 8'hA5; valid_a = 1'b1;
      @(posedge clk); #1 valid_a = 1'b0;
      check_frame("a5", 8'hA5);

      // 8'hFF offered throughout 8'h0F, taken only after it
      data_a = 8'h0F; valid_a = 1'b1;
      @(posedge clk); #1 data_a = 8'hFF;
      check_frame("0f", 8'h0F);
      @(posedge clk); #1 valid_a = 1'b0;
      check_frame("ff", 8'hFF);

      // Back-to-back 8'h01 then 8'h80
      data_a = 8'h01; valid_a = 1'b1;
      @(posedge clk); #1 data_a = 8'h80;
      check_frame("01", 8'h01);
      @(posedge clk); #1 valid_a = 1'b0;
      check_frame("80", 8'h80);

      // Parity-sensitive words (parity 1 and 0)
      data_a = 8'h07; valid_a = 1'b1;
      @(posedge clk); #1 valid_a = 1'b0;
      check_frame("07", 8'h07);
      data_a = 8'h03; valid_a = 1'b1;
      @(posedge clk); #1 valid_a = 1'b0;
      check_frame("03", 8'h03);

      // MSB-first, one bit per clock
      wb = 8'hC0;
      data_b = wb; valid_b = 1'b1;
      @(posedge clk); #1 valid_b = 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
         chk("c0 out",   {31'd0, out_b},   {31'd0, (i < 8) ? wb[3'(7 - i)] : ^wb});
         chk("c0 frame", {31'd0, frame_b}, 32'd1);
         chk("c0 done",  {31'd0, done_b},  32'd0);
         @(posedge clk); #1;
      end
      chk("c0 done pulse", {31'd0, done_b},  32'd1);
      chk("c0 done frame", {31'd0, frame_b}, 32'd0);
      @(posedge clk); #1;
      chk("c0 idle ready", {31'd0, ready_b}, 32'd1);
      chk("c0 idle done",  {31'd0, done_b},  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
